// File: rtl/traffic_phase_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tlc_pkg
// Brief    : Shared types, default timing constants and phase-scan helper for
//            the traffic phase controller.
// Revision : 1.0 - initial release
// ============================================================================
package tlc_pkg;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2,
        FLASH   = 2'd3
    } state_t;

    localparam int unsigned C_DEF_TICK_DIV     = 10;
    localparam int unsigned C_DEF_GREEN_TICKS  = 6;
    localparam int unsigned C_DEF_YELLOW_TICKS = 2;
    localparam int unsigned C_DEF_ALLRED_TICKS = 1;
    localparam int unsigned C_MAX_PHASES       = 8;

    // Cyclic scan for the first latched phase after 'current'; phase 0 if none.
    function automatic logic [2:0] next_phase(
        input logic [7:0]  latches,
        input logic [2:0]  current,
        input int unsigned num_phases
    );
        logic [2:0]  result;
        logic        found;
        int unsigned q;
        result = 3'd0;
        found  = 1'b0;
        for (int unsigned k = 1; k < C_MAX_PHASES; k++) begin
            q = (32'(current) + k) % num_phases;
            if (!found && (k < num_phases) && latches[q[2:0]]) begin
                result = q[2:0];
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_phase_controller_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Brief    : Prescaler producing a one-cycle tick every DIV clock cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    generate
        if (DIV == 1) begin : g_div_one
            logic r_tick;
            always_ff @(posedge clk) begin
                if (rst) r_tick <= 1'b0;
                else     r_tick <= 1'b1;
            end
            assign tick = r_tick;
        end else begin : g_div_n
            localparam int unsigned C_CNT_W = $clog2(DIV);
            localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(DIV - 1);
            logic [C_CNT_W-1:0] r_count;
            always_ff @(posedge clk) begin
                if (rst || (r_count == C_LAST)) r_count <= '0;
                else                            r_count <= r_count + C_CNT_W'(1);
            end
            assign tick = (r_count == C_LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/traffic_phase_controller.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_controller
// Brief    : Demand-actuated N-phase signal sequencer (GREEN/YELLOW/ALL_RED).
//            Define TLC_FLASH_EN to add the flash_req input and FLASH state.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_controller
    import tlc_pkg::*;
#(
    parameter int unsigned NUM_PHASES   = 4,
    parameter int unsigned TICK_DIV     = C_DEF_TICK_DIV,
    parameter int unsigned GREEN_TICKS  = C_DEF_GREEN_TICKS,
    parameter int unsigned YELLOW_TICKS = C_DEF_YELLOW_TICKS,
    parameter int unsigned ALLRED_TICKS = C_DEF_ALLRED_TICKS,
    parameter int unsigned TIMER_W      = 6
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef TLC_FLASH_EN
    input  logic                          flash_req,
`endif
    input  logic [NUM_PHASES-1:0]         demand,
    output logic [NUM_PHASES-1:0]         red,
    output logic [NUM_PHASES-1:0]         yellow,
    output logic [NUM_PHASES-1:0]         green,
    output logic [$clog2(NUM_PHASES)-1:0] phase,
    output logic [TIMER_W-1:0]            timer,
    output logic                          tick
);

    localparam int unsigned C_PHASE_W = $clog2(NUM_PHASES);
    localparam logic [TIMER_W-1:0] C_GREEN_LD  = TIMER_W'(GREEN_TICKS - 1);
    localparam logic [TIMER_W-1:0] C_YELLOW_LD = TIMER_W'(YELLOW_TICKS - 1);
    localparam logic [TIMER_W-1:0] C_ALLRED_LD = TIMER_W'(ALLRED_TICKS - 1);

    state_t                  r_state, w_state;
    logic [TIMER_W-1:0]      r_timer, w_timer;
    logic [C_PHASE_W-1:0]    r_phase, w_phase, w_target;
    logic [NUM_PHASES-1:0]   r_latch, w_latch;
    logic                    r_force_main, w_force_main;
    logic                    w_enter_green;
    logic                    w_unused_demand0;
`ifdef TLC_FLASH_EN
    logic                    r_flash_yel, w_flash_yel;
`endif

    assign w_unused_demand0 = demand[0];

    tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ALL_RED;
            r_timer      <= C_ALLRED_LD;
            r_phase      <= '0;
            r_latch      <= '0;
            r_force_main <= 1'b1;
`ifdef TLC_FLASH_EN
            r_flash_yel  <= 1'b0;
`endif
        end else begin
            r_state      <= w_state;
            r_timer      <= w_timer;
            r_phase      <= w_phase;
            r_latch      <= w_latch;
            r_force_main <= w_force_main;
`ifdef TLC_FLASH_EN
            r_flash_yel  <= w_flash_yel;
`endif
        end
    end

    // r_force_main steers the first green after reset or flash exit to phase 0.
    always_comb begin
        w_state       = r_state;
        w_timer       = r_timer;
        w_phase       = r_phase;
        w_force_main  = r_force_main;
        w_enter_green = 1'b0;
`ifdef TLC_FLASH_EN
        w_flash_yel   = r_flash_yel;
`endif
        w_target = r_force_main ? '0 :
                   C_PHASE_W'(next_phase(8'(r_latch), 3'(r_phase), NUM_PHASES));
        if (tick) begin
`ifdef TLC_FLASH_EN
            if (flash_req && (r_state != FLASH)) begin
                w_state     = FLASH;
                w_timer     = '0;
                w_phase     = '0;
                w_flash_yel = 1'b1;
            end else
`endif
            case (r_state)
                ALL_RED: begin
                    if (r_timer == '0) begin
                        w_state       = GREEN;
                        w_phase       = w_target;
                        w_timer       = C_GREEN_LD;
                        w_force_main  = 1'b0;
                        w_enter_green = 1'b1;
                    end else begin
                        w_timer = r_timer - TIMER_W'(1);
                    end
                end
                GREEN: begin
                    if (r_timer != '0) begin
                        w_timer = r_timer - TIMER_W'(1);
                    end else if ((r_phase != '0) || (|r_latch)) begin
                        w_state = YELLOW;
                        w_timer = C_YELLOW_LD;
                    end
                end
                YELLOW: begin
                    if (r_timer == '0) begin
                        w_state = ALL_RED;
                        w_timer = C_ALLRED_LD;
                    end else begin
                        w_timer = r_timer - TIMER_W'(1);
                    end
                end
`ifdef TLC_FLASH_EN
                FLASH: begin
                    if (flash_req) begin
                        w_flash_yel = ~r_flash_yel;
                    end else begin
                        w_state      = ALL_RED;
                        w_timer      = C_ALLRED_LD;
                        w_phase      = '0;
                        w_force_main = 1'b1;
                    end
                end
`endif
                default: begin
                    w_state = ALL_RED;
                    w_timer = C_ALLRED_LD;
                end
            endcase
        end

        // Demand for the phase being served is dropped from entry until green ends.
        w_latch = '0;
        for (int i = 1; i < NUM_PHASES; i++) begin
            if (w_enter_green && (w_phase == C_PHASE_W'(i)))
                w_latch[i] = 1'b0;
            else if ((r_state == GREEN) && (r_phase == C_PHASE_W'(i)))
                w_latch[i] = r_latch[i];
            else
                w_latch[i] = r_latch[i] | demand[i];
        end
    end

    always_comb begin
        red    = '1;
        yellow = '0;
        green  = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (r_phase == C_PHASE_W'(i)) begin
                if (r_state == GREEN) begin
                    red[i]   = 1'b0;
                    green[i] = 1'b1;
                end else if (r_state == YELLOW) begin
                    red[i]    = 1'b0;
                    yellow[i] = 1'b1;
                end
            end
        end
`ifdef TLC_FLASH_EN
        if (r_state == FLASH) begin
            red    = '0;
            green  = '0;
            yellow = {NUM_PHASES{r_flash_yel}};
        end
`endif
    end

    assign phase = r_phase;
    assign timer = r_timer;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_phase_controller
// Brief    : Scoreboard bench: expected lamp segments are queued by the
//            stimulus and checked by a monitor on every lamp change.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_controller;

    localparam int NP  = 4;
    localparam int DIV = 10;
    localparam int GT  = 6;
    localparam int YT  = 2;
    localparam int AT  = 1;
    localparam int TW  = 6;

    localparam int K_AR = 0;
    localparam int K_G  = 1;
    localparam int K_Y  = 2;
    localparam int K_F1 = 3;
    localparam int K_F0 = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] demand = '0;
`ifdef TLC_FLASH_EN
    logic          flash_req = 1'b0;
`endif
    logic [NP-1:0] red, yellow, green;
    logic [1:0]    phase;
    logic [TW-1:0] timer;
    logic          tick;

    always #5 clk = ~clk;

    traffic_phase_controller #(
        .NUM_PHASES   (NP),
        .TICK_DIV     (DIV),
        .GREEN_TICKS  (GT),
        .YELLOW_TICKS (YT),
        .ALLRED_TICKS (AT),
        .TIMER_W      (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef TLC_FLASH_EN
        .flash_req (flash_req),
`endif
        .demand    (demand),
        .red       (red),
        .yellow    (yellow),
        .green     (green),
        .phase     (phase),
        .timer     (timer),
        .tick      (tick)
    );

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] y;
        logic [3:0] g;
        logic [1:0] ph;
        logic [5:0] tm;
    } view_t;

    typedef struct {
        view_t v;
        int    len;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic view_t mk(input int kind, input int p);
        view_t      v;
        logic [3:0] sel;
        sel  = 4'b0001 << p;
        v.r  = 4'b1111;
        v.y  = 4'b0000;
        v.g  = 4'b0000;
        v.ph = 2'(p);
        v.tm = 6'd0;
        case (kind)
            K_G:  begin v.r = ~sel; v.g = sel; v.tm = 6'(GT - 1); end
            K_Y:  begin v.r = ~sel; v.y = sel; v.tm = 6'(YT - 1); end
            K_AR: v.tm = 6'(AT - 1);
            K_F1: begin v.r = 4'b0000; v.y = 4'b1111; end
            K_F0: v.r = 4'b0000;
            default: v.tm = 6'd0;
        endcase
        return v;
    endfunction

    task automatic push(input int kind, input int p, input int len);
        sb.push_back('{v: mk(kind, p), len: len});
    endtask

    // Monitor: each lamp change closes a segment (length check) and opens the next.
    view_t cur_v, prev_v;
    exp_t  e;
    int    seg_count = 0;
    int    cur_len   = 0;
    bit    was_rst   = 1'b1;

    always @(negedge clk) begin
        cur_v = '{red, yellow, green, phase, timer};
        if (rst) begin
            was_rst = 1'b1;
        end else if (was_rst) begin
            was_rst   = 1'b0;
            prev_v    = cur_v;
            seg_count = 1;
            cur_len   = DIV * AT;
        end else if ({cur_v.r, cur_v.y, cur_v.g, cur_v.ph} !=
                     {prev_v.r, prev_v.y, prev_v.g, prev_v.ph}) begin
            if (cur_len != 0)
                check(seg_count == cur_len, "seg_len", 64'(seg_count), 64'(cur_len));
            check(sb.size() != 0, "unexpected_change", 64'(cur_v), 64'(prev_v));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check(cur_v == e.v, "seg_view", 64'(cur_v), 64'(e.v));
                cur_len = e.len;
            end else begin
                cur_len = 0;
            end
            prev_v    = cur_v;
            seg_count = 1;
        end else begin
            seg_count++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_lamp(input bit is_yellow, input int idx, input int max, input string name);
        int k;
        bit hit;
        k   = 0;
        hit = 1'b0;
        while (k < max && !hit) begin
            @(posedge clk);
            #1;
            k++;
            hit = is_yellow ? yellow[idx] : green[idx];
        end
        check(hit, name, 64'(k), 64'(max));
    endtask

    task automatic wait_sb(input int size, input int max, input string name);
        int k;
        k = 0;
        while (k < max && sb.size() > size) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(sb.size() <= size, name, 64'(sb.size()), 64'(size));
    endtask

    task automatic check_reset(input string name);
        check({red, yellow, green, phase, timer, tick} == {4'hF, 4'h0, 4'h0, 2'd0, 6'd0, 1'b0},
              name, 64'({red, yellow, green, phase, timer, tick}),
              64'({4'hF, 4'h0, 4'h0, 2'd0, 6'd0, 1'b0}));
    endtask

    task automatic check_rest(input string name);
        check({red, yellow, green, phase, timer} == {4'b1110, 4'h0, 4'b0001, 2'd0, 6'd0},
              name, 64'({red, yellow, green, phase, timer}),
              64'({4'b1110, 4'h0, 4'b0001, 2'd0, 6'd0}));
    endtask

    initial begin
        // Reset and idle rest on phase 0
        rst = 1'b1;
        cycles(3);
        check_reset("reset_values");
        push(K_G, 0, 0);
        rst = 1'b0;
        cycles(120);
        check_rest("idle_rest");

        // Single demand on phase 2 from rest
        push(K_Y, 0, YT * DIV);
        push(K_AR, 0, AT * DIV);
        push(K_G, 2, GT * DIV);
        push(K_Y, 2, YT * DIV);
        push(K_AR, 2, AT * DIV);
        push(K_G, 0, 0);
        demand = 4'b0100;
        cycles(1);
        demand = 4'b0000;
        wait_sb(0, 300, "p2_service_done");
        cycles(100);
        check_rest("p2_back_to_rest");

        // Phases 1 and 3 requested together
        push(K_Y, 0, YT * DIV);
        push(K_AR, 0, AT * DIV);
        push(K_G, 1, GT * DIV);
        push(K_Y, 1, YT * DIV);
        push(K_AR, 1, AT * DIV);
        push(K_G, 3, GT * DIV);
        push(K_Y, 3, YT * DIV);
        push(K_AR, 3, AT * DIV);
        push(K_G, 0, 0);
        demand = 4'b1010;
        cycles(1);
        demand = 4'b0000;
        wait_sb(0, 400, "p1_p3_service_done");
        cycles(100);
        check_rest("p1_p3_back_to_rest");

        // Demand held through its own green is not re-latched
        push(K_Y, 0, YT * DIV);
        push(K_AR, 0, AT * DIV);
        push(K_G, 2, GT * DIV);
        push(K_Y, 2, YT * DIV);
        push(K_AR, 2, AT * DIV);
        push(K_G, 0, 0);
        demand = 4'b0100;
        wait_lamp(1'b0, 2, 100, "held_wait_green2");
        cycles(50);
        demand = 4'b0000;
        wait_sb(0, 200, "held_service_done");
        cycles(100);
        check_rest("held_no_relatch");

        // Reset in the middle of phase-3 yellow with phase 1 pending
        push(K_Y, 0, YT * DIV);
        push(K_AR, 0, AT * DIV);
        push(K_G, 3, GT * DIV);
        push(K_Y, 3, 0);
        demand = 4'b1000;
        cycles(1);
        demand = 4'b0000;
        wait_lamp(1'b1, 3, 200, "wait_yellow3");
        demand = 4'b0010;
        cycles(1);
        demand = 4'b0000;
        cycles(2);
        push(K_G, 0, 0);
        rst = 1'b1;
        cycles(1);
        check_reset("midrun_reset_values");
        rst = 1'b0;
        cycles(150);
        check_rest("reset_cleared_latches");

`ifdef TLC_FLASH_EN
        // Flash entered during green 1, released after four flash ticks
        push(K_Y, 0, YT * DIV);
        push(K_AR, 0, AT * DIV);
        push(K_G, 1, 0);
        push(K_F1, 0, DIV);
        push(K_F0, 0, DIV);
        push(K_F1, 0, DIV);
        push(K_F0, 0, DIV);
        push(K_AR, 0, AT * DIV);
        push(K_G, 0, 0);
        demand = 4'b0010;
        cycles(1);
        demand = 4'b0000;
        wait_lamp(1'b0, 1, 200, "flash_wait_green1");
        cycles(20);
        flash_req = 1'b1;
        wait_sb(2, 200, "flash_toggles");
        cycles(3);
        flash_req = 1'b0;
        wait_sb(0, 100, "flash_exit_done");
        cycles(100);
        check_rest("flash_back_to_rest");
`endif

        check(sb.size() == 0, "scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
